adbg_jsp_rx_unpack: RTL and testbench
=====================================

Name: adbg_jsp_rx_unpack

Overview:
- Downstream stage of the JTAG Serial Port data register (DBG_JSP_DATAREG_LEN = 64 bits).
- Consumes each completed 64-bit host-to-target data-register word, which carries a byte count and up to 7 payload bytes.
- Serialises the valid bytes, in order, onto a byte-wide valid/ready stream that feeds the target-side RX FIFO.
- Decouples the single-shot word delivery from a byte consumer that can stall.

Parameters:
- DATAREG_LEN, 64, width of the incoming data-register word; must equal DBG_JSP_DATAREG_LEN.
- MAX_BYTES, 7, maximum payload bytes per word.
- CNT_W, 4, width of the count field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- word_i  in  DATAREG_LEN  data-register word: [3:0] byte count; [11:4] byte0; [19:12] byte1; … [59:52] byte6; [63:60] ignored.
- word_valid_i  in  1  word_i valid.
- word_ready_o  out  1  block can accept a word this cycle.
- byte_o  out  8  current output byte.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  consumer accepts byte_o.
- bad_count_o  out  1  one-cycle pulse: the accepted word had count > MAX_BYTES.
- busy_o  out  1  high while bytes remain to be emitted.

Behaviour:
- Reset (async assert, sync release) puts the block in IDLE:
  - byte_valid_o=0, byte_o=0, bad_count_o=0, busy_o=0.
  - Remaining counter=0 and shift register=0.
  - word_ready_o is combinational; it is 1 in IDLE.
- FSM states: IDLE and SHIFT.
- IDLE:
  - word_ready_o=1.
  - A word is accepted on word_valid_i & word_ready_o.
  - On accept, latch payload bits [59:4] into the shift register. Set remaining = min(count, MAX_BYTES).
  - Count > 7: clamp to 7 and pulse bad_count_o in the following cycle.
  - remaining=0: the word is consumed, no byte is output, and the FSM stays in IDLE.
  - remaining>0: go to SHIFT. byte_valid_o=1 and byte_o=byte0 in the cycle after accept (latency 1).
- SHIFT:
  - byte_valid_o=1 and busy_o=1.
  - byte_o = shift register [7:0]. It is held stable while byte_ready_i=0.
  - On byte_valid_o & byte_ready_i: shift right by 8 with zero fill, and decrement remaining.
  - If remaining was 1, return to IDLE with byte_valid_o=0 next cycle, unless a new word is accepted in the same cycle.
- Back-to-back words:
  - word_ready_o = IDLE | (SHIFT & remaining==1 & byte_ready_i).
  - A word accepted in the last-byte handshake cycle reloads directly. No bubble: byte0 of the new word is valid next cycle.
  - If the new word has count 0, go to IDLE.
- Counter width: remaining is 3 bits (0..7); it never wraps because decrement occurs only when remaining>0.
- word_valid_i while word_ready_o=0: ignored. The upstream holds the word (valid/ready contract).
- bad_count_o is asserted exactly one cycle per offending word. A simultaneous reload in the same cycle does not suppress it.
- Reset mid-SHIFT:
  - Outputs drop immediately (async) and the partial word is discarded.
  - After release the block is in IDLE and accepts a word in the first active edge.
- byte_o is zero when byte_valid_o=0.

Test Plan:
- Reset, then word count=3, bytes 0x41,0x42,0x43, byte_ready_i=1:
  - byte_o 0x41,0x42,0x43 on 3 consecutive cycles starting 1 cycle after accept.
  - Then byte_valid_o=0, busy_o=0.
- Count=2 with byte_ready_i low for 4 cycles:
  - byte_o holds byte0 with valid=1 during the stall.
  - word_ready_o=0 throughout.
  - Byte1 follows one cycle after ready rises.
- Count=0 word: accepted in 1 cycle, byte_valid_o never asserts, word_ready_o stays 1.
- Count=0xF with bytes 0x10..0x16:
  - bad_count_o pulses once.
  - Exactly 7 bytes 0x10..0x16 are emitted.
- Back-to-back with word_valid_i held, count=1 (0xAA) then count=2 (0xBB,0xCC):
  - Output 0xAA,0xBB,0xCC on 3 consecutive cycles with no bubble.
- Assert rst_i asynchronously mid-word (after 2 of 5 bytes):
  - byte_valid_o drops at once.
  - After release, a new count=1 word emits only its byte.

Source files
------------

// File: rtl/adbg_jsp_rx_unpack.sv
// adbg_jsp_rx_unpack
// Takes each completed host-to-target JSP data-register word (byte count plus
// up to MAX_BYTES payload bytes) and replays the valid bytes, lowest first,
// onto a byte-wide valid/ready stream feeding the target RX FIFO.
module adbg_jsp_rx_unpack #(
  parameter int DATAREG_LEN = 64,
  parameter int MAX_BYTES   = 7,
  parameter int CNT_W       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATAREG_LEN-1:0] word_i,
  input  logic                   word_valid_i,
  output logic                   word_ready_o,
  output logic [7:0]             byte_o,
  output logic                   byte_valid_o,
  input  logic                   byte_ready_i,
  output logic                   bad_count_o,
  output logic                   busy_o
);

  localparam int PAY_W = MAX_BYTES * 8;
  localparam int REM_W = $clog2(MAX_BYTES + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_r;
  logic [REM_W-1:0]   remaining_r;
  logic [PAY_W-1:0]   shift_r;
  logic               bad_count_r;

  logic [CNT_W-1:0]   count_s;
  logic [PAY_W-1:0]   payload_s;
  logic               over_s;
  logic [REM_W-1:0]   load_count_s;
  logic               word_ready_s;
  logic               accept_s;
  logic               last_byte_s;

  // Bits above the payload carry nothing for this stage.
  logic               unused_bits_s;
  assign unused_bits_s = ^word_i[DATAREG_LEN-1:CNT_W+PAY_W];

  // Decode the incoming word, clamp its count and work out handshake readiness.
  always_comb begin
    count_s      = word_i[CNT_W-1:0];
    payload_s    = word_i[CNT_W +: PAY_W];
    over_s       = 1'b0;
    load_count_s = '0;
    word_ready_s = 1'b0;
    last_byte_s  = 1'b0;

    if (count_s > CNT_W'(MAX_BYTES)) begin
      over_s       = 1'b1;
      load_count_s = REM_W'(MAX_BYTES);
    end else begin
      over_s       = 1'b0;
      load_count_s = count_s[REM_W-1:0];
    end

    if (remaining_r == REM_W'(1)) begin
      last_byte_s = 1'b1;
    end else begin
      last_byte_s = 1'b0;
    end

    // A new word may land in the same cycle the final byte is taken, so the
    // stream keeps going without a bubble between words.
    case (state_r)
      ST_IDLE:  word_ready_s = 1'b1;
      ST_SHIFT: word_ready_s = last_byte_s & byte_ready_i;
      default:  word_ready_s = 1'b0;
    endcase

    accept_s = word_valid_i & word_ready_s;
  end

  // Unpacking FSM: loads accepted words and shifts out one byte per handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      remaining_r <= '0;
      shift_r     <= '0;
      bad_count_r <= 1'b0;
    end else begin
      bad_count_r <= accept_s & over_s;
      if (accept_s) begin
        if (load_count_s != '0) begin
          state_r     <= ST_SHIFT;
          remaining_r <= load_count_s;
          shift_r     <= payload_s;
        end else begin
          // Empty word: swallow it and keep byte_o at zero.
          state_r     <= ST_IDLE;
          remaining_r <= '0;
          shift_r     <= '0;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r     <= ST_IDLE;
            remaining_r <= remaining_r;
            shift_r     <= shift_r;
          end
          ST_SHIFT: begin
            if (byte_ready_i) begin
              if (last_byte_s) begin
                // Clear leftovers so byte_o reads zero while idle.
                state_r     <= ST_IDLE;
                remaining_r <= '0;
                shift_r     <= '0;
              end else begin
                state_r     <= ST_SHIFT;
                remaining_r <= remaining_r - REM_W'(1);
                shift_r     <= {8'h00, shift_r[PAY_W-1:8]};
              end
            end else begin
              state_r     <= ST_SHIFT;
              remaining_r <= remaining_r;
              shift_r     <= shift_r;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            remaining_r <= '0;
            shift_r     <= '0;
          end
        endcase
      end
    end
  end

  assign word_ready_o = word_ready_s;
  assign byte_o       = shift_r[7:0];
  assign byte_valid_o = (state_r == ST_SHIFT);
  assign busy_o       = (state_r == ST_SHIFT);
  assign bad_count_o  = bad_count_r;

endmodule

// File: tb/tb_adbg_jsp_rx_unpack.sv
// Directed bench for adbg_jsp_rx_unpack. Inputs change 1 ns after the rising
// edge and outputs are sampled there too, away from the active edge.
module tb_adbg_jsp_rx_unpack;

  logic        clk_i;
  logic        rst_i;
  logic [63:0] word_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic        bad_count_o;
  logic        busy_o;

  int checks;
  int errors;

  adbg_jsp_rx_unpack #(
    .DATAREG_LEN(64),
    .MAX_BYTES  (7),
    .CNT_W      (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .word_i      (word_i),
    .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_o),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i),
    .bad_count_o (bad_count_o),
    .busy_o      (busy_o)
  );

  // 100 MHz clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Build a data-register word: payload holds byte0 in its lowest 8 bits.
  function automatic logic [63:0] mkword(input logic [3:0] cnt, input logic [55:0] payload,
                                         input logic [3:0] top);
    return {top, payload, cnt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic valid, input logic [7:0] data,
                         input logic busy, input logic bad);
    chk({tag, ".valid"}, {31'd0, byte_valid_o}, {31'd0, valid});
    chk({tag, ".byte"},  {24'd0, byte_o},       {24'd0, data});
    chk({tag, ".busy"},  {31'd0, busy_o},       {31'd0, busy});
    chk({tag, ".bad"},   {31'd0, bad_count_o},  {31'd0, bad});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_i        = 1'b1;
    word_i       = 64'd0;
    word_valid_i = 1'b0;
    byte_ready_i = 1'b1;

    // Reset state
    step();
    step();
    chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset.wready", {31'd0, word_ready_o}, 32'd1);
    rst_i = 1'b0;
    step();

    // Count 3, consumer always ready
    word_i       = mkword(4'd3, 56'h00000000_434241, 4'h0);
    word_valid_i = 1'b1;
    step();
    word_valid_i = 1'b0;
    chk_out("w3.b0", 1'b1, 8'h41, 1'b1, 1'b0);
    step();
    chk_out("w3.b1", 1'b1, 8'h42, 1'b1, 1'b0);
    step();
    chk_out("w3.b2", 1'b1, 8'h43, 1'b1, 1'b0);
    step();
    chk_out("w3.end", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("w3.end.wready", {31'd0, word_ready_o}, 32'd1);

    // Count 2 with a 4-cycle consumer stall
    byte_ready_i = 1'b0;
    word_i       = mkword(4'd2, 56'h00000000_006655, 4'h0);
    word_valid_i = 1'b1;
    step();
    word_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out("stall.hold", 1'b1, 8'h55, 1'b1, 1'b0);
      chk("stall.wready", {31'd0, word_ready_o}, 32'd0);
      if (i < 3) step();
    end
    byte_ready_i = 1'b1;
    chk("stall.rel.wready", {31'd0, word_ready_o}, 32'd0);
    step();
    chk_out("stall.b1", 1'b1, 8'h66, 1'b1, 1'b0);
    chk("stall.last.wready", {31'd0, word_ready_o}, 32'd1);
    step();
    chk_out("stall.end", 1'b0, 8'h00, 1'b0, 1'b0);

    // Count 0: consumed in one cycle, nothing emitted
    word_i       = mkword(4'd0, 56'h99887766_554433, 4'h0);
    word_valid_i = 1'b1;
    chk("c0.wready.pre", {31'd0, word_ready_o}, 32'd1);
    step();
    word_valid_i = 1'b0;
    chk_out("c0.after", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("c0.wready", {31'd0, word_ready_o}, 32'd1);
    step();
    chk_out("c0.later", 1'b0, 8'h00, 1'b0, 1'b0);

    // Count 0xF: clamped to 7 bytes, one bad_count pulse, top nibble ignored
    word_i       = mkword(4'hF, 56'h16151413121110, 4'hA);
    word_valid_i = 1'b1;
    step();
    word_valid_i = 1'b0;
    chk_out("cf.b0", 1'b1, 8'h10, 1'b1, 1'b1);
    for (int i = 1; i < 7; i++) begin
      step();
      chk_out("cf.bn", 1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
    end
    step();
    chk_out("cf.end", 1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back: count 1 (AA) then count 2 (BB, CC), valid held
    word_i       = mkword(4'd1, 56'h00000000_0000AA, 4'h0);
    word_valid_i = 1'b1;
    step();
    chk_out("b2b.aa", 1'b1, 8'hAA, 1'b1, 1'b0);
    word_i = mkword(4'd2, 56'h00000000_00CCBB, 4'h0);
    chk("b2b.wready", {31'd0, word_ready_o}, 32'd1);
    step();
    word_valid_i = 1'b0;
    chk_out("b2b.bb", 1'b1, 8'hBB, 1'b1, 1'b0);
    step();
    chk_out("b2b.cc", 1'b1, 8'hCC, 1'b1, 1'b0);
    step();
    chk_out("b2b.end", 1'b0, 8'h00, 1'b0, 1'b0);

    // Async reset after 2 of 5 bytes, then a fresh count-1 word
    word_i       = mkword(4'd5, 56'h00000504_030201, 4'h0);
    word_valid_i = 1'b1;
    step();
    word_valid_i = 1'b0;
    chk_out("rst.b0", 1'b1, 8'h01, 1'b1, 1'b0);
    step();
    chk_out("rst.b1", 1'b1, 8'h02, 1'b1, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    chk_out("rst.async", 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    rst_i = 1'b0;
    word_i       = mkword(4'd1, 56'h00000000_000077, 4'h0);
    word_valid_i = 1'b1;
    chk("rst.rel.wready", {31'd0, word_ready_o}, 32'd1);
    step();
    word_valid_i = 1'b0;
    chk_out("rst.new", 1'b1, 8'h77, 1'b1, 1'b0);
    step();
    chk_out("rst.new.end", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
